// File: rtl/hiscore_ram_sequencer.sv
// High-score save/restore sequencer between the HPS ioctl channel and game work RAM.
// Restore bytes are FIFO-buffered and written only inside vblank; save reads fetch RAM on demand.
module hiscore_ram_sequencer #(
  parameter int unsigned       ADDR_W     = 10,
  parameter int unsigned       HS_INDEX   = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 10'h0A8,
  parameter int unsigned       TABLE_LEN  = 64,
  parameter int unsigned       FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  input  logic              vblank,
  input  logic [7:0]        ram_q,
  output logic [ADDR_W-1:0] ram_address,
  output logic [7:0]        ram_data_in,
  output logic              ram_data_write,
  output logic              busy,
  output logic              restore_done,
  output logic              overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_SETUP, S_WR_STROBE, S_RD_ADDR, S_RD_WAIT, S_RD_LATCH
  } state_t;

  state_t              state_q, state_d;
  logic [PW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic                dl_q, dl_d, up_q, up_d;
  logic [24:0]         last_off_q, last_off_d;
  logic                req_q, req_d;
  logic [7:0]          din_q, din_d;
  logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
  logic [7:0]          data_hold_q, data_hold_d;
  logic                started_q, started_d, fell_q, fell_d;

  logic [ADDR_W+7:0]   fifo_mem [FIFO_DEPTH];

  logic                hs_sel, in_range, push_req, push_en, pop;
  logic                empty, full, dl_rise, new_off, new_req;
  logic [ADDR_W+7:0]   head;

  always_comb begin
    hs_sel   = (ioctl_index == 8'(HS_INDEX));
    in_range = (ioctl_addr < 25'(TABLE_LEN));
    push_req = ioctl_download & ioctl_wr & hs_sel & in_range;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    pop      = (state_q == S_WR_STROBE);
    // A pop in the same cycle frees the slot, so a push on full is still accepted.
    push_en  = push_req & (~full | pop);
    head     = fifo_mem[rd_ptr_q[PW-1:0]];
    dl_rise  = ioctl_download & ~dl_q & hs_sel;
    new_off  = ioctl_upload & hs_sel & ((ioctl_addr != last_off_q) | ~up_q);
    new_req  = new_off & in_range;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_q | new_req)     state_d = S_RD_ADDR;
        else if (~empty & vblank) state_d = S_WR_SETUP;
      end
      S_WR_SETUP:  state_d = vblank ? S_WR_STROBE : S_IDLE;
      S_WR_STROBE: state_d = S_IDLE;
      S_RD_ADDR:   state_d = S_RD_WAIT;
      S_RD_WAIT:   state_d = S_RD_LATCH;
      S_RD_LATCH:  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_data_write = (state_q == S_WR_STROBE);
    ram_address    = addr_hold_q;
    ram_data_in    = data_hold_q;
    case (state_q)
      S_WR_SETUP, S_WR_STROBE: begin
        ram_address = BASE_ADDR + head[ADDR_W+7:8];
        ram_data_in = head[7:0];
      end
      S_RD_ADDR, S_RD_WAIT, S_RD_LATCH: ram_address = BASE_ADDR + last_off_q[ADDR_W-1:0];
      default: ;
    endcase
    addr_hold_d  = ram_address;
    data_hold_d  = ram_data_in;
    ioctl_din    = din_q;
    overflow     = overflow_q;
    busy         = ~empty | (state_q != S_IDLE);
    restore_done = fell_q & empty & (state_q == S_IDLE);
  end

  always_comb begin
    wr_ptr_d   = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    dl_d       = ioctl_download;
    up_d       = ioctl_upload;

    overflow_d = overflow_q;
    if (dl_rise)              overflow_d = 1'b0;
    if (push_req & ~push_en)  overflow_d = 1'b1;

    started_d = started_q;
    fell_d    = fell_q;
    if (restore_done) begin
      started_d = 1'b0;
      fell_d    = 1'b0;
    end
    if (dl_rise) begin
      started_d = 1'b1;
      fell_d    = 1'b0;
    end else if (started_q & dl_q & ~ioctl_download) begin
      fell_d = 1'b1;
    end

    req_d      = req_q;
    last_off_d = last_off_q;
    din_d      = din_q;
    if (state_q == S_RD_LATCH && req_q) begin
      din_d = ram_q;
      req_d = 1'b0;
    end
    // Out-of-range offsets answer immediately and never start a RAM read.
    if (new_off) begin
      last_off_d = ioctl_addr;
      req_d      = in_range;
      if (!in_range) din_d = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      dl_q        <= 1'b0;
      up_q        <= 1'b0;
      last_off_q  <= '0;
      req_q       <= 1'b0;
      din_q       <= 8'hFF;
      addr_hold_q <= '0;
      data_hold_q <= '0;
      started_q   <= 1'b0;
      fell_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      dl_q        <= dl_d;
      up_q        <= up_d;
      last_off_q  <= last_off_d;
      req_q       <= req_d;
      din_q       <= din_d;
      addr_hold_q <= addr_hold_d;
      data_hold_q <= data_hold_d;
      started_q   <= started_d;
      fell_q      <= fell_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) fifo_mem[wr_ptr_q[PW-1:0]] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout};
  end

endmodule
